// File: rtl/piece_locker_if.sv
// piece_locker_if: bundles the lock request, piece window and board/result
// signals shared by the game controller (master) and piece_locker (slave).
// `static` is a reserved word, so the board vector is named static_board.
// `float` is renamed float_mask to match.
interface piece_locker_if;
    logic        start;
    logic        clear;
    logic [3:0]  pos_x;
    logic [4:0]  pos_y;
    logic [0:15] float_mask;     // bit r*4+c = window row r, column c
    logic [0:199] static_board;  // bit row*10+col, row 0 at top
    logic        busy;
    logic        done;
    logic [2:0]  lines_cleared;
    logic        top_out;
    logic [15:0] score;

    modport master (
        output start, clear, pos_x, pos_y, float_mask,
        input  static_board, busy, done, lines_cleared, top_out, score
    );

    modport slave (
        input  start, clear, pos_x, pos_y, float_mask,
        output static_board, busy, done, lines_cleared, top_out, score
    );
endinterface

// File: rtl/piece_locker.sv
// piece_locker: merges the landed 4x4 piece into the 10x20 static board,
// removes full rows one row per cycle (bottom up), and reports the count.
// Optional macro PIECE_LOCKER_SCORE_EN adds a saturating score accumulator;
// without it, score is tied to zero.
module piece_locker (
    input  logic clk,
    input  logic rst,
    piece_locker_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MERGE = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [4:0] LAST_ROW = 5'd19;

    logic [1:0]   state_q, state_d;
    logic [4:0]   scan_row_q, scan_row_d;
    logic [3:0]   pos_x_q, pos_x_d;
    logic [4:0]   pos_y_q, pos_y_d;
    logic [0:15]  float_q, float_d;
    logic [0:199] board_q, board_d;
    logic [2:0]   lines_q, lines_d;
    logic         top_out_q, top_out_d;

    logic [19:0]  row_full;
    logic [5:0]   m_col, m_row;
    logic [7:0]   m_idx;

    // Per-row fullness flags of the current board.
    always_comb begin
        for (int i = 0; i < 20; i++) begin
            row_full[i] = &board_q[i*10 +: 10];
        end
    end

    // Next-state logic: lock sequence, with clear overriding every state.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        state_d    = state_q;
        scan_row_d = scan_row_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        float_d    = float_q;
        board_d    = board_q;
        lines_d    = lines_q;
        top_out_d  = top_out_q;
        m_col      = '0;
        m_row      = '0;
        m_idx      = '0;

        if (bus.clear) begin
            state_d    = S_IDLE;
            scan_row_d = '0;
            board_d    = '0;
            lines_d    = '0;
            top_out_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        pos_x_d = bus.pos_x;
                        pos_y_d = bus.pos_y;
                        float_d = bus.float_mask;
                        lines_d = '0;
                        state_d = S_MERGE;
                    end
                end
                S_MERGE: begin
                    // Coordinates are widened to 6 bits so off-board cells
                    // compare as out of range instead of wrapping.
                    for (int r = 0; r < 4; r++) begin
                        for (int c = 0; c < 4; c++) begin
                            if (float_q[r*4 + c]) begin
                                m_col = {2'b00, pos_x_q} + 6'(c);
                                m_row = {1'b0, pos_y_q} + 6'(r);
                                if (m_col < 6'd10 && m_row < 6'd20) begin
                                    m_idx = 8'(m_row) * 8'd10 + 8'(m_col);
                                    board_d[m_idx] = 1'b1;
                                end
                            end
                        end
                    end
                    scan_row_d = LAST_ROW;
                    state_d    = S_SCAN;
                end
                S_SCAN: begin
                    if (row_full[scan_row_q]) begin
                        // Drop everything above the full row by one; the
                        // row index stays so the shifted-in row is rechecked.
                        board_d[0 +: 10] = '0;
                        for (int i = 1; i < 20; i++) begin
                            if (5'(i) <= scan_row_q) begin
                                board_d[i*10 +: 10] = board_q[(i-1)*10 +: 10];
                            end
                        end
                        if (lines_q != 3'd7) begin
                            lines_d = lines_q + 3'd1;
                        end
                    end else if (scan_row_q != 5'd0) begin
                        scan_row_d = scan_row_q - 5'd1;
                    end else begin
                        top_out_d = |board_q[0 +: 10];
                        state_d   = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= S_IDLE;
            scan_row_q <= '0;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            float_q    <= '0;
            // NOTE: the board is a flop vector, not a RAM, because reset and
            // clear must zero all 200 cells in one edge.
            board_q    <= '0;
            lines_q    <= '0;
            top_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_row_q <= scan_row_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            float_q    <= float_d;
            board_q    <= board_d;
            lines_q    <= lines_d;
            top_out_q  <= top_out_d;
        end
    end

`ifdef PIECE_LOCKER_SCORE_EN
    logic [15:0] score_q, score_d;
    logic        enter_done;
    logic [16:0] score_sum;

    function automatic logic [3:0] line_points(input logic [2:0] k);
        case (k)
            3'd0:    line_points = 4'd0;
            3'd1:    line_points = 4'd1;
            3'd2:    line_points = 4'd3;
            3'd3:    line_points = 4'd5;
            default: line_points = 4'd8;
        endcase
    endfunction

    // Score accumulates on the edge entering DONE, saturating at all ones.
    always_comb begin
        enter_done = (state_q == S_SCAN) && !row_full[scan_row_q]
                     && (scan_row_q == 5'd0);
        score_sum  = {1'b0, score_q} + 17'(line_points(lines_q));
        score_d    = score_q;
        if (bus.clear) begin
            score_d = '0;
        end else if (enter_done) begin
            score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end

    // Score register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign bus.score = score_q;
`else
    assign bus.score = 16'd0;
`endif

    assign bus.static_board  = board_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = (state_q == S_DONE);
    assign bus.lines_cleared = lines_q;
    assign bus.top_out       = top_out_q;

endmodule

// File: doc/piece_locker.md
# piece_locker

Writer side of the playfield: when the game controller decides the falling piece has landed, this block merges the 4×4 floating piece into the 10×20 static board register. It then scans for full rows, removes them, and reports how many rows were cleared. It owns the `static` board vector that the collision check and the renderer read, and it is the only block that modifies that vector.

## Interface
Parameters: none.

- `clk` in 1: system clock.
- `rst` in 1: reset; **synchronous and active-high**.
- `start` in 1: lock request; sampled only in IDLE.
- `clear` in 1: wipe the board (new game).
- `pos_x` in 4: anchor column of the 4×4 window's top-left cell.
- `pos_y` in 5: anchor row of the 4×4 window's top-left cell.
- `float` in [0:15]: piece mask; bit r*4+c is window row r, column c.
- `static` out [0:199]: board; bit row*10+col, row 0 at top, col 0 at left.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the lock sequence completes.
- `lines_cleared` out 3: rows removed by the last lock; held until the next `start` or `clear`.
- `top_out` out 1: row 0 is non-empty after the last lock; held.
- `score` out 16: running score; see Configuration.

## Operation
- States: IDLE, MERGE, SCAN, DONE.
- IDLE:
  - `start`=1 latches `pos_x`, `pos_y` and `float`, zeroes `lines_cleared`, and moves to MERGE.
  - `start` in any other state is ignored.
- MERGE (1 cycle):
  - For each set float bit, target cell is col = pos_x+c, row = pos_y+r, computed in 6 bits so nothing wraps.
  - If col ≥ 10 or row ≥ 20, the cell is dropped silently. Otherwise it is ORed into `static`.
  - Moves to SCAN with row index 19.
- SCAN, one row per cycle, row r:
  - Row r all ones: rows 1..r take the contents of rows 0..r-1, row 0 becomes zero, `lines_cleared` increments (saturating at 7), and r is unchanged so the shifted-in row is rechecked.
  - Row r not full and r > 0: r decrements.
  - Row r not full and r = 0: move to DONE.
- DONE (1 cycle):
  - `done`=1.
  - `top_out` is set to OR of row 0.
  - Score updates (if enabled).
  - Returns to IDLE.
- `clear`:
  - Has priority over everything in any state.
  - On the next edge: `static`=0, `lines_cleared`=0, `top_out`=0, `score`=0, state IDLE, no `done` pulse.
  - A `start` in the same cycle is dropped.
- `rst` has the same effect as `clear`: all outputs 0, state IDLE.

## Timing
- `done` is a registered state decode. It is high during the cycle after edge E+21+k, where E is the edge that samples `start` and k is the number of rows cleared. Range: 21 (k=0) to 25 (k=4).
- `static` changes only on the MERGE edge and on SCAN edges that clear a row. Readers must not sample it while `busy`=1.
- `busy` rises on edge E and falls on the edge that leaves DONE.
- A back-to-back `start` is accepted in the first IDLE cycle after DONE.

## Configuration
- `PIECE_LOCKER_SCORE_EN` defined:
  - On entering DONE, `score` adds 0, 1, 3, 5 or 8 for k = 0, 1, 2, 3, ≥4.
  - The sum saturates at 16'hFFFF.
  - The score is reset by `rst` or `clear`.
- Not defined: the accumulator is not synthesized and `score` is tied to 16'd0.

## Test plan
- Reset:
  - Stimulus: assert `rst` for 2 cycles.
  - Required: `static`=0, `busy`=0, `done`=0, `lines_cleared`=0, `top_out`=0, `score`=0.
- Simple lock:
  - Stimulus: `float` bits 4..7 set, `pos_x`=0, `pos_y`=18, `start` pulse.
  - Required: row 19 cols 0..3 set, `done` at E+21, `lines_cleared`=0.
- Single clear:
  - Setup: row 19 cols 0..7 filled, row 18 empty.
  - Stimulus: O piece (`float` bits 0,1,4,5) at `pos_x`=8, `pos_y`=18.
  - Required: row 19 holds only cols 8..9, row 18 empty, `done` at E+22, `lines_cleared`=1, `score`+1 with the macro.
- Four-line clear:
  - Setup: rows 16..19 cols 0..8 filled.
  - Stimulus: vertical I (`float` bits 0,4,8,12) at `pos_x`=9, `pos_y`=16.
  - Required: rows 16..19 empty, `done` at E+25, `lines_cleared`=4, `score`+8 with the macro and 0 without.
- Off-board and top-out:
  - Stimulus: `float` bits 0..3 set at `pos_x`=8, `pos_y`=0.
  - Required: only row 0 cols 8 and 9 set, `top_out`=1 at `done`.
- Abort and ignore:
  - Stimulus: `start` again 5 cycles after E.
  - Required: that `start` is ignored.
  - Stimulus: `clear` at E+10.
  - Required: next edge gives `static`=0 and `busy`=0, and no `done` pulse follows.
